mem_reader: RTL and testbench

Sequential read-out controller for the 8-entry × 8-bit register memory. It acts as the read-side initiator: on a start pulse it walks a programmable address window, drives the memory's read enable and address, captures each returned byte, and presents it on a valid/ready output stream with a last marker. It sits between the memory and any downstream consumer (UART transmitter, checker) and leaves the write side untouched.

---
 rtl/mem_reader_pkg.sv | 17 +
 rtl/mem_reader_if.sv | 31 +++
 rtl/mem_reader.sv | 114 +++++++++++
 tb/tb_mem_reader.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_reader_pkg.sv
// Shared definitions for the register-memory read-out controller.
// The size defaults match the 8 x 8-bit register memory it reads.
package mem_reader_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPTURE,
        ST_SEND,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mem_reader_if.sv
// Memory read port plus the valid/ready output stream of the reader.
// The master side is the reader; the slave side is the memory and the consumer.
interface mem_reader_if #(
    parameter int DATA_W = mem_reader_pkg::DATA_W,
    parameter int ADDR_W = mem_reader_pkg::ADDR_W
);

    logic              mem_read_en;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_empty_flag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output mem_read_en, mem_address,
        input  mem_data_out, mem_empty_flag,
        output out_valid, out_data, out_last,
        input  out_ready
    );

    modport slave (
        input  mem_read_en, mem_address,
        output mem_data_out, mem_empty_flag,
        input  out_valid, out_data, out_last,
        output out_ready
    );

endinterface

// File: rtl/mem_reader.sv
// Walks an address window of the register memory on a start pulse and streams
// each byte out on a valid/ready port, flagging the final word with out_last.
module mem_reader
    import mem_reader_pkg::*;
#(
    parameter int DATA_W = mem_reader_pkg::DATA_W,
    parameter int ADDR_W = mem_reader_pkg::ADDR_W,
    parameter int DEPTH  = mem_reader_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    mem_reader_if.master      bus,
    output logic              busy,
    output logic              done,
    output logic              empty_err
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   remain_q;
    logic [DATA_W-1:0] data_q;
    logic              last_q;
    logic              err_q;

    logic              read_en;
    logic              valid;
    logic              busy_c;
    logic              done_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d = state_q;
        read_en = 1'b0;
        valid   = 1'b0;
        busy_c  = 1'b1;
        done_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy_c = 1'b0;
                if (start) state_d = bus.mem_empty_flag ? ST_DONE : ST_READ;
            end
            ST_READ: begin
                read_en = 1'b1;
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: state_d = ST_SEND;
            ST_SEND: begin
                valid = 1'b1;
                if (bus.out_ready) state_d = last_q ? ST_DONE : ST_READ;
            end
            ST_DONE: begin
                done_c  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy_c  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q   <= '0;
            remain_q <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && bus.mem_empty_flag) begin
                        err_q <= 1'b1;
                    end else if (start) begin
                        addr_q   <= base_addr;
                        // A zero length means a full sweep of the memory.
                        remain_q <= (length == '0) ? (ADDR_W+1)'(DEPTH) : length;
                    end
                end
                ST_CAPTURE: begin
                    data_q <= bus.mem_data_out;
                    last_q <= (remain_q == (ADDR_W+1)'(1));
                end
                ST_SEND: begin
                    if (bus.out_ready) begin
                        remain_q <= remain_q - (ADDR_W+1)'(1);
                        addr_q   <= addr_q + ADDR_W'(1);
                    end
                end
                ST_DONE: err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.mem_read_en = read_en;
    assign bus.mem_address = addr_q;
    assign bus.out_valid   = valid;
    assign bus.out_data    = data_q;
    assign bus.out_last    = last_q & valid;
    assign busy            = busy_c;
    assign done            = done_c;
    assign empty_err       = err_q;

endmodule

// File: tb/tb_mem_reader.sv
// Self-checking bench for mem_reader: a behavioural memory, a stream monitor and
// per-scenario tasks comparing against word lists derived from the memory contents.
module tb_mem_reader;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       start = 1'b0;
    logic [2:0] base_addr = '0;
    logic [3:0] length = '0;
    logic       busy, done, empty_err;

    mem_reader_if bus_if ();

    mem_reader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .bus       (bus_if.master),
        .busy      (busy),
        .done      (done),
        .empty_err (empty_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] mem [8];

    initial begin
        bus_if.mem_empty_flag = 1'b0;
        bus_if.out_ready      = 1'b1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read memory: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (bus_if.mem_read_en) bus_if.mem_data_out <= mem[bus_if.mem_address];
    end

    // Stream monitor, sampled on the falling edge.
    logic [8:0] got [$];
    int rd_cnt, rd_first, valid_first, done_cnt, done_cyc, err_cnt, b2b;
    bit prev_rd;

    task automatic clear_mon();
        got.delete();
        rd_cnt = 0; rd_first = -1; valid_first = -1;
        done_cnt = 0; done_cyc = -1; err_cnt = 0; b2b = 0; prev_rd = 0;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus_if.mem_read_en) begin
                if (rd_cnt == 0) rd_first = cyc;
                rd_cnt++;
                if (prev_rd) b2b++;
            end
            prev_rd = bus_if.mem_read_en;
            if (bus_if.out_valid && valid_first < 0) valid_first = cyc;
            if (bus_if.out_valid && bus_if.out_ready) got.push_back({bus_if.out_last, bus_if.out_data});
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (empty_err) err_cnt++;
            end
        end
    end

    // Expected stream for a burst: addresses wrap modulo 8, length 0 means 8.
    function automatic int eff_len(input int l);
        return (l == 0) ? 8 : l;
    endfunction

    function automatic logic [8:0] exp_word(input int b, input int l, input int i);
        logic last;
        last = (i == eff_len(l) - 1);
        return {last, mem[(b + i) % 8]};
    endfunction

    task automatic start_burst(input int b, input int l, output int n);
        clear_mon();
        base_addr = 3'(b);
        length    = 4'(l);
        start     = 1'b1;
        @(posedge clk); #1;
        n = cyc;
        start     = 1'b0;
        base_addr = 3'($urandom);
        length    = 4'($urandom);
    endtask

    task automatic wait_done(input bit rnd_ready, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
            if (rnd_ready) bus_if.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        bus_if.out_ready = 1'b1;
    endtask

    function automatic logic [16:0] out_vec();
        return {bus_if.mem_read_en, bus_if.mem_address, bus_if.out_valid, bus_if.out_data,
                bus_if.out_last, busy, done, empty_err};
    endfunction

    task automatic fill_counting();
        for (int i = 0; i < 8; i++) mem[i] = 8'(8'h11 * (i + 1));
    endtask

    task automatic test_reset();
        logic [16:0] v;
        reset_n = 1'b0;
        #3;
        v = out_vec();
        checks++;
        if (v !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs actual=%h required=0", v);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        v = out_vec();
        checks++;
        if (v !== 17'd0) begin
            errors++;
            $display("FAIL idle_after_reset actual=%h required=0", v);
        end
    endtask

    task automatic test_empty();
        int n; bit ok;
        bus_if.mem_empty_flag = 1'b1;
        start_burst(3, 5, n);
        wait_done(1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL empty_timeout actual=no_done required=done"); end
        checks++;
        if (done_cyc !== n) begin errors++; $display("FAIL empty_done_cycle actual=%0d required=%0d", done_cyc, n); end
        checks++;
        if (err_cnt !== 1) begin errors++; $display("FAIL empty_err_with_done actual=%0d required=1", err_cnt); end
        checks++;
        if (rd_cnt !== 0 || valid_first !== -1) begin
            errors++;
            $display("FAIL empty_no_activity actual=rd%0d/valid%0d required=rd0/valid-1", rd_cnt, valid_first);
        end
        checks++;
        if (busy !== 1'b0 || empty_err !== 1'b0) begin
            errors++;
            $display("FAIL empty_cleared actual=busy%b/err%b required=0/0", busy, empty_err);
        end
        bus_if.mem_empty_flag = 1'b0;
    endtask

    task automatic test_full_sweep();
        int n; bit ok;
        fill_counting();
        start_burst(0, 0, n);
        wait_done(1'b0, ok);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (!ok || got.size() !== 8) begin
            errors++;
            $display("FAIL full_count actual=%0d required=8", got.size());
        end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            checks++;
            if (got[i] !== exp_word(0, 0, i)) begin
                errors++;
                $display("FAIL full_word%0d actual=%h required=%h", i, got[i], exp_word(0, 0, i));
            end
        end
        checks++;
        if (rd_first !== n || valid_first !== n + 2 || done_cyc !== n + 24) begin
            errors++;
            $display("FAIL full_timing actual=%0d/%0d/%0d required=%0d/%0d/%0d",
                     rd_first, valid_first, done_cyc, n, n + 2, n + 24);
        end
        checks++;
        if (done_cnt !== 1 || busy !== 1'b0 || b2b !== 0 || err_cnt !== 0) begin
            errors++;
            $display("FAIL full_status actual=done%0d/busy%b/b2b%0d/err%0d required=1/0/0/0",
                     done_cnt, busy, b2b, err_cnt);
        end
    endtask

    task automatic test_wrap();
        int n; bit ok;
        logic [8:0] req [4];
        req = '{9'h077, 9'h088, 9'h011, 9'h122};
        fill_counting();
        start_burst(6, 4, n);
        wait_done(1'b0, ok);
        checks++;
        if (!ok || got.size() !== 4) begin
            errors++;
            $display("FAIL wrap_count actual=%0d required=4", got.size());
        end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            checks++;
            if (got[i] !== req[i]) begin
                errors++;
                $display("FAIL wrap_word%0d actual=%h required=%h", i, got[i], req[i]);
            end
        end
        checks++;
        if (done_cyc !== n + 12) begin errors++; $display("FAIL wrap_done_cycle actual=%0d required=%0d", done_cyc, n + 12); end
    endtask

    task automatic test_backpressure();
        int n, rd0; bit ok;
        fill_counting();
        start_burst(1, 3, n);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            ok = (got.size() == 1);
        end
        bus_if.out_ready = 1'b0;
        for (int i = 0; i < 20 && !bus_if.out_valid; i++) begin
            @(posedge clk); #1;
        end
        rd0 = rd_cnt;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (!ok || bus_if.out_valid !== 1'b1 || {bus_if.out_last, bus_if.out_data} !== {1'b0, mem[2]}) begin
                errors++;
                $display("FAIL stall_hold%0d actual=v%b/%b/%h required=v1/0/%h",
                         i, bus_if.out_valid, bus_if.out_last, bus_if.out_data, mem[2]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (rd_cnt !== rd0 || rd0 !== 2 || got.size() !== 1) begin
            errors++;
            $display("FAIL stall_no_read actual=rd%0d->%0d/words%0d required=rd2->2/words1", rd0, rd_cnt, got.size());
        end
        bus_if.out_ready = 1'b1;
        wait_done(1'b0, ok);
        checks++;
        if (!ok || got.size() !== 3 || rd_cnt !== 3) begin
            errors++;
            $display("FAIL stall_complete actual=words%0d/rd%0d required=3/3", got.size(), rd_cnt);
        end
        for (int i = 0; i < got.size() && i < 3; i++) begin
            checks++;
            if (got[i] !== exp_word(1, 3, i)) begin
                errors++;
                $display("FAIL stall_word%0d actual=%h required=%h", i, got[i], exp_word(1, 3, i));
            end
        end
    endtask

    task automatic test_ignore_start();
        int n; bit ok;
        fill_counting();
        start_burst(2, 5, n);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; base_addr = 3'd0; length = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1'b0, ok);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (!ok || got.size() !== 5 || rd_cnt !== 5 || done_cnt !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start actual=words%0d/rd%0d/done%0d/busy%b required=5/5/1/0",
                     got.size(), rd_cnt, done_cnt, busy);
        end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            checks++;
            if (got[i] !== exp_word(2, 5, i)) begin
                errors++;
                $display("FAIL ignore_word%0d actual=%h required=%h", i, got[i], exp_word(2, 5, i));
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int n; bit ok;
        logic [16:0] v;
        fill_counting();
        start_burst(0, 3, n);
        for (int i = 0; i < 20 && got.size() < 1; i++) begin
            @(posedge clk); #1;
        end
        bus_if.out_ready = 1'b0;
        for (int i = 0; i < 20 && !bus_if.out_valid; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (bus_if.out_valid !== 1'b1 || got.size() !== 1) begin
            errors++;
            $display("FAIL midrst_reach_send actual=v%b/words%0d required=v1/words1", bus_if.out_valid, got.size());
        end
        #2 reset_n = 1'b0;
        #1 v = out_vec();
        checks++;
        if (v !== 17'd0) begin errors++; $display("FAIL midrst_outputs actual=%h required=0", v); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus_if.out_ready = 1'b1;
        start_burst(5, 1, n);
        wait_done(1'b0, ok);
        checks++;
        if (!ok || got.size() !== 1 || rd_cnt !== 1) begin
            errors++;
            $display("FAIL midrst_restart actual=words%0d/rd%0d required=1/1", got.size(), rd_cnt);
        end else begin
            checks++;
            if (got[0] !== {1'b1, mem[5]}) begin
                errors++;
                $display("FAIL midrst_word actual=%h required=%h", got[0], {1'b1, mem[5]});
            end
        end
    endtask

    task automatic test_random();
        int n, b, l; bit ok;
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
            b = $urandom_range(0, 7);
            l = $urandom_range(0, 8);
            start_burst(b, l, n);
            wait_done(1'b1, ok);
            checks++;
            if (!ok || got.size() !== eff_len(l) || rd_cnt !== eff_len(l) || done_cnt !== 1 || b2b !== 0 || err_cnt !== 0) begin
                errors++;
                $display("FAIL rand%0d_status b=%0d l=%0d actual=words%0d/rd%0d/done%0d/b2b%0d required=%0d/%0d/1/0",
                         t, b, l, got.size(), rd_cnt, done_cnt, b2b, eff_len(l), eff_len(l));
            end
            for (int i = 0; i < got.size() && i < eff_len(l); i++) begin
                checks++;
                if (got[i] !== exp_word(b, l, i)) begin
                    errors++;
                    $display("FAIL rand%0d_word%0d actual=%h required=%h", t, i, got[i], exp_word(b, l, i));
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        clear_mon();
        fill_counting();
        #2;
        test_reset();
        test_empty();
        test_full_sweep();
        test_wrap();
        test_backpressure();
        test_ignore_start();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
